// File: rtl/gost89_gamma_ctrl.sv
// GOST 28147-89 counter-mode (gamma) sequencer driving an external ECB core.
// It encrypts the sync vector once, then steps and encrypts the counter per block to form the keystream.
module gost89_gamma_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [63:0] sync_in,
  input  logic        data_valid,
  input  logic [63:0] data_in,
  output logic        data_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        core_load,
  output logic [63:0] core_in,
  input  logic [63:0] core_out,
  input  logic        core_busy,
  output logic [2:0]  dbg_state
);

  localparam logic [31:0] C2 = 32'h01010101;
  localparam logic [31:0] C1 = 32'h01010104;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SYNC_LOAD = 3'd1,
    SYNC_WAIT = 3'd2,
    READY     = 3'd3,
    G_LOAD    = 3'd4,
    G_WAIT    = 3'd5,
    OUT       = 3'd6
  } state_t;

  state_t      state, state_next;
  logic [31:0] hi, lo;
  logic [63:0] dreg;
  logic [63:0] out_reg;
  logic        seen_busy;

  logic        load_sync, sync_done, step, gamma_done;
  logic [32:0] hi_sum;
  logic [31:0] hi_next, lo_next;

  // High word adds modulo 2^32-1: the end-around carry keeps FFFFFFFF as a legal value.
  assign hi_sum  = {1'b0, hi} + {1'b0, C1};
  assign hi_next = hi_sum[32] ? hi_sum[31:0] + 32'd1 : hi_sum[31:0];
  assign lo_next = lo + C2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid/out_data hold until out_ready, and data_ready drops while start is asserted.
  assign data_ready = (state == READY) && !start;
  assign out_valid  = (state == OUT);
  assign out_data   = out_reg;
  assign busy       = (state != IDLE) && (state != READY);
  assign core_load  = (state == SYNC_LOAD) || (state == G_LOAD);
  assign core_in    = {hi, lo};
  assign dbg_state  = state;

  always_comb begin
    state_next = state;
    load_sync  = 1'b0;
    sync_done  = 1'b0;
    step       = 1'b0;
    gamma_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_sync  = 1'b1;
          state_next = SYNC_LOAD;
        end
      end
      SYNC_LOAD: state_next = SYNC_WAIT;
      SYNC_WAIT: begin
        if (seen_busy && !core_busy) begin
          sync_done  = 1'b1;
          state_next = READY;
        end
      end
      READY: begin
        if (start) begin
          load_sync  = 1'b1;
          state_next = SYNC_LOAD;
        end else if (data_valid) begin
          step       = 1'b1;
          state_next = G_LOAD;
        end
      end
      G_LOAD: state_next = G_WAIT;
      G_WAIT: begin
        if (seen_busy && !core_busy) begin
          gamma_done = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_next = READY;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hi        <= '0;
      lo        <= '0;
      dreg      <= '0;
      out_reg   <= '0;
      seen_busy <= 1'b0;
    end else begin
      state <= state_next;
      if (load_sync) begin
        {hi, lo} <= sync_in;
      end else if (sync_done) begin
        {hi, lo} <= core_out;
      end else if (step) begin
        hi <= hi_next;
        lo <= lo_next;
      end
      if (step) dreg <= data_in;
      if (gamma_done) out_reg <= dreg ^ core_out;
      // Completion needs busy seen high first, so early low samples are ignored.
      if (core_load) seen_busy <= 1'b0;
      else if ((state == SYNC_WAIT || state == G_WAIT) && core_busy) seen_busy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gost89_gamma_ctrl.sv
// Directed bench for gost89_gamma_ctrl with an inverting, 32-cycle-busy ECB core model.
module tb_gost89_gamma_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] sync_in = '0;
  logic        data_valid = 1'b0;
  logic [63:0] data_in = '0;
  logic        data_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        core_load;
  logic [63:0] core_in;
  logic [63:0] core_out;
  logic        core_busy;
  logic [2:0]  dbg_state;

  int unsigned total = 0;
  int unsigned passed = 0;
  logic [63:0] exp_q[$];
  logic [63:0] ctr_m;

  // Core model: out = ~in, busy for 32 cycles starting the cycle after load; not reset by reset_n.
  logic [63:0] core_out_r = '0;
  int          core_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_load) begin
      core_out_r <= ~core_in;
      core_cnt   <= 32;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end
  end
  assign core_out  = core_out_r;
  assign core_busy = (core_cnt != 0);

  gost89_gamma_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .sync_in    (sync_in),
    .data_valid (data_valid),
    .data_in    (data_in),
    .data_ready (data_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .core_load  (core_load),
    .core_in    (core_in),
    .core_out   (core_out),
    .core_busy  (core_busy),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] step_ctr(input logic [63:0] c);
    logic [32:0] s;
    logic [31:0] h, l;
    s = {1'b0, c[63:32]} + 33'h0_01010104;
    h = s[32] ? s[31:0] + 32'd1 : s[31:0];
    l = c[31:0] + 32'h01010101;
    return {h, l};
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!data_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) check({tag, "_ready_timeout"}, 64'(data_ready), 64'd1);
  endtask

  task automatic do_sync(input logic [63:0] s);
    @(negedge clk);
    start   = 1'b1;
    sync_in = s;
    @(negedge clk);
    start = 1'b0;
    check("sync_core_load", 64'(core_load), 64'd1);
    check("sync_core_in", core_in, s);
    ctr_m = ~s;
    wait_ready("sync");
  endtask

  task automatic send_block(input logic [63:0] d, input bit push);
    wait_ready("send");
    data_valid = 1'b1;
    data_in    = d;
    @(negedge clk);
    data_valid = 1'b0;
    ctr_m = step_ctr(ctr_m);
    check("gload_core_load", 64'(core_load), 64'd1);
    check("gload_counter", core_in, ctr_m);
    if (push) exp_q.push_back(d ^ ~ctr_m);
  endtask

  task automatic get_out(input int hold, output logic [63:0] obs);
    int n = 0;
    logic [63:0] held;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_rise", 64'(out_valid), 64'd1);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", out_data, held);
      check("hold_ready_low", 64'(data_ready), 64'd0);
    end
    obs = out_data;
    if (exp_q.size() == 0) check("scoreboard_empty", 64'd1, 64'd0);
    else check("out_data", out_data, exp_q.pop_front());
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("after_out_ready", 64'(data_ready), 64'd1);
  endtask

  logic [63:0] r, d1, o1;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_data", out_data, 64'd0);
    check("rst_flags", {59'd0, out_valid, data_ready, busy, core_load, 1'b0}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    data_valid = 1'b1;
    @(negedge clk);
    check("idle_ignores_data", 64'(dbg_state), 64'd0);
    data_valid = 1'b0;

    // Sync then two blocks without restart
    do_sync(64'd0);
    send_block(64'd0, 1'b1);
    check("blk1_counter_const", core_in, 64'h01010104_01010100);
    get_out(0, r);
    check("blk1_const", r, 64'hFEFEFEFB_FEFEFEFF);
    send_block(64'd0, 1'b1);
    check("blk2_counter_const", core_in, 64'h02020208_02020201);
    get_out(0, r);
    check("blk2_const", r, 64'hFDFDFDF7_FDFDFDFE);

    // Mod 2^32-1 edge: hi reaches FFFFFFFF then wraps to 01010104
    do_sync(~64'hFEFEFEFB_00000000);
    send_block(64'd0, 1'b1);
    check("edge_hi1", {32'd0, core_in[63:32]}, 64'h0000_0000_FFFF_FFFF);
    get_out(0, r);
    send_block(64'd0, 1'b1);
    check("edge_hi2", {32'd0, core_in[63:32]}, 64'h0000_0000_0101_0104);
    get_out(0, r);

    // Involution with random data
    d1 = {$urandom_range(32'hFFFF_FFFF, 0), $urandom_range(32'hFFFF_FFFF, 0)};
    do_sync(64'h0123_4567_89AB_CDEF);
    send_block(d1, 1'b1);
    get_out(0, o1);
    do_sync(64'h0123_4567_89AB_CDEF);
    send_block(o1, 1'b1);
    get_out(0, r);
    check("involution", r, d1);

    // Reset mid G_WAIT, then stale core completion must be ignored
    do_sync(64'd0);
    send_block(64'd0, 1'b0);
    repeat (5) @(negedge clk);
    check("pre_rst_gwait", 64'(dbg_state), 64'd5);
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    check("mid_rst_flags", {60'd0, out_valid, data_ready, busy, core_load}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("stale_ignored", {61'd0, dbg_state}, 64'd0);
    do_sync(64'd0);
    send_block(64'd0, 1'b1);
    get_out(0, r);
    check("post_rst_const", r, 64'hFEFEFEFB_FEFEFEFF);

    // start and data_valid together in READY: reload wins
    @(negedge clk);
    start      = 1'b1;
    sync_in    = ~64'hFEFEFEFB_00000000;
    data_valid = 1'b1;
    data_in    = 64'hDEAD_BEEF_0000_0001;
    #1;
    check("start_gates_ready", 64'(data_ready), 64'd0);
    @(negedge clk);
    start      = 1'b0;
    data_valid = 1'b0;
    check("start_wins_state", 64'(dbg_state), 64'd1);
    check("start_wins_core_in", core_in, ~64'hFEFEFEFB_00000000);
    ctr_m = 64'hFEFEFEFB_00000000;
    wait_ready("reload");
    send_block(64'h0F0F_0F0F_F0F0_F0F0, 1'b1);
    get_out(10, r);
    check("bp_value", r, 64'h0F0F_0F0F_F0F0_F0F0 ^ 64'h0000_0000_FEFE_FEFE);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gost89_gamma_ctrl.md
# gost89_gamma_ctrl

Counter-mode ("gamma") sequencer for GOST 28147-89. It sits directly upstream of an external `gost89_ecb_encrypt` core and drives it through the core's `load_data`/`in`/`out`/`busy` port set. It encrypts the synchronization vector once, then steps the 64-bit counter with the GOST constants for each data block and encrypts it to form the keystream. Each returned keystream block is XORed with buffered plaintext or ciphertext and presented on a valid/ready output. Encryption and decryption are the same operation.

## Interface
- No parameters; constants are fixed: C2 = 32'h01010101 (low word), C1 = 32'h01010104 (high word).
- `clk` in 1 — single clock; all logic on the rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — load a new sync vector; sampled only in IDLE or READY.
- `sync_in` in 64 — synchronization vector, captured with `start`.
- `data_valid` in 1 — input block valid.
- `data_in` in 64 — plaintext or ciphertext block.
- `data_ready` out 1 — block can accept `data_in`.
- `out_valid` out 1 — `out_data` valid.
- `out_data` out 64 — `data_in ^ gamma`.
- `out_ready` in 1 — downstream accepts `out_data`.
- `busy` out 1 — high in every state except IDLE and READY.
- `core_load` out 1 — one-cycle load pulse to the ECB core (its `load_data`).
- `core_in` out 64 — block to the ECB core.
- `core_out` in 64 — ECB core result.
- `core_busy` in 1 — ECB core busy.

## Operation
- Counter register `{hi,lo}` (64 bit), data register `dreg` (64 bit) and output register (64 bit).
- FSM states: IDLE, SYNC_LOAD, SYNC_WAIT, READY, G_LOAD, G_WAIT, OUT.
- IDLE: `start` → capture `sync_in` into `{hi,lo}`, go to SYNC_LOAD. `data_valid` is ignored.
- SYNC_LOAD: `core_load`=1, `core_in`={hi,lo}, go to SYNC_WAIT.
- SYNC_WAIT: wait for `core_busy` to be seen high and then low. On the first low cycle after that, `{hi,lo}` <= `core_out`, go to READY.
- READY: `data_ready`=1. The rules below are checked in this order:
  - `start`=1 → reload the sync vector as in IDLE. A coincident `data_valid` is not accepted, because `data_ready` is forced to 0 when `start`=1.
  - `data_valid`=1 → update the counter, latch `dreg`<=`data_in`, go to G_LOAD.
    - lo <= lo + C2 mod 2^32.
    - hi: s = {1'b0,hi} + C1 (33 bit); hi <= s[32] ? s[31:0] + 1 : s[31:0]. This is addition mod 2^32−1 with 32'hFFFFFFFF kept as a legal value.
- G_LOAD: `core_load`=1, `core_in`={hi,lo} (the updated counter), go to G_WAIT.
- G_WAIT: same busy-high-then-low rule as SYNC_WAIT. Then output register <= `dreg ^ core_out`, go to OUT.
- OUT: `out_valid`=1. When `out_ready`=1, return to READY. The counter persists across blocks.
- `core_load` is asserted only in SYNC_LOAD and G_LOAD. `core_in` holds {hi,lo} in every state.
- `start` outside IDLE and READY is ignored; there is no abort path.

## Timing
- Reset values: FSM=IDLE, `{hi,lo}`=0, `dreg`=0, `out_data`=0, `data_ready`=0, `out_valid`=0, `busy`=0, `core_load`=0.
- All outputs are registered or decoded from FSM state only. `data_ready` is additionally gated by `~start`.
- Sync phase: `start` sampled at edge T → `core_load` high during cycle T+1 → READY on the edge after the first qualifying `core_busy`=0 sample.
- Data phase: accept at edge T (`data_valid & data_ready`) → `core_load` high during cycle T+1. With a core whose busy lasts N cycles, `out_valid` rises N+2 cycles after `core_load`, ±1 depending on when the core raises busy.
- Throughput: one block per core latency plus 3 cycles. There is no pipelining; one block is in flight at a time.
- Backpressure: `out_valid` and `out_data` hold stable until `out_ready`. `data_ready` stays 0 until the OUT handshake completes.
- `reset_n` low at any time forces all reset values immediately, including mid G_WAIT. The core is not reset by this block, so a stale core completion after `reset_n` rises is ignored because the FSM is in IDLE.
- Any `core_busy` low samples seen in SYNC_WAIT or G_WAIT before busy has gone high are ignored.

## Test plan
Bench core model: `out` = ~`in`, `busy` high for 32 cycles starting the cycle after `load`.
- Sync then one block: `sync_in`=0, `start`, then `data_in`=0 → gamma counter {01010104,01010100}; `out_data`=64'hFEFEFEFB_FEFEFEFF, `out_valid` held until `out_ready`.
- Second block without restart: `data_in`=0 → counter {02020208,02020201}; `out_data`=64'hFDFDFDF7_FDFDFDFE.
- Mod 2^32−1 edge: `sync_in`=~64'hFEFEFEFB_00000000 (S hi=FEFEFEFB) → first hi=FFFFFFFF; second hi=01010104; `out_data` with `data_in`=0 equals ~counter each time.
- Involution: feed block 1's `out_data` back in after a re-`start` with the same sync → recovers the original `data_in`.
- `reset_n` pulsed low mid G_WAIT → all outputs 0 at once, IDLE. A fresh sync and block yield the scenario 1 value.
- `start` and `data_valid` together in READY → `data_ready`=0 and the sync reload wins. `out_ready`=0 for 10 cycles → `out_data` stable and `data_ready`=0 throughout.
